// File: rtl/video_text_ovl.sv
// Purpose : 32x24 character-cell text overlay that feeds a 1-bit dot and aligned blanking flag to the video mixer.
// Latency : 5 enabled (CK_EE_i=1) clocks from HCTRs_i/VCTRs_i/XBLK_i to PIX_o/XBLK_o.
// Backpressure: none; host writes are dropped with a WR_ERR_o pulse while clearing or when the address is out of range.
//
// Ports:
//   CK_i, XARST_i, CK_EE_i   clock, async active-low reset, clock enable (all state holds when low)
//   HCTRs_i, VCTRs_i, XBLK_i raster position and active-video flag from the timing generator
//   WR_i, WR_As_i, WR_DATs_i host text write (address = row*32+col, 7-bit character code)
//   CLR_i                    start a fill of the whole buffer with C_BLANK
//   FONT_As_o, FONT_DATs_i   external 5x7 font ROM {glyph,line} address and returned dot row
//   PIX_o, XBLK_o            text dot and delayed active-video flag
//   BUSY_o, WR_ERR_o         clear in progress, rejected-write pulse
module video_text_ovl #(
  parameter int unsigned C_H0    = 192,
  parameter int unsigned C_V0    = 40,
  parameter int unsigned C_COLS  = 32,
  parameter int unsigned C_ROWS  = 24,
  parameter logic [6:0]  C_BLANK = 7'h20
) (
  input  logic       CK_i,
  input  logic       XARST_i,
  input  logic       CK_EE_i,
  input  logic [9:0] HCTRs_i,
  input  logic [8:0] VCTRs_i,
  input  logic       XBLK_i,
  input  logic       WR_i,
  input  logic [9:0] WR_As_i,
  input  logic [6:0] WR_DATs_i,
  input  logic       CLR_i,
  output logic [8:0] FONT_As_o,
  input  logic [4:0] FONT_DATs_i,
  output logic       PIX_o,
  output logic       XBLK_o,
  output logic       BUSY_o,
  output logic       WR_ERR_o
);

  localparam logic [9:0] N_CELLS   = 10'(C_COLS * C_ROWS);
  localparam logic [9:0] LAST_CELL = N_CELLS - 10'd1;

  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

  // Text buffer: not reset, filled by the clear engine instead.
  logic [6:0] txt_mem [0:767];

  clr_state_t st_q, st_d;
  logic [9:0] clr_a_q, clr_a_d;
  logic       wr_err_q, wr_err_d;

  // S0
  logic [4:0] col0_q, col0_d, row0_q, row0_d;
  logic [2:0] dot0_q, dot0_d, line0_q, line0_d;
  logic       win0_q, win0_d, xblk0_q, xblk0_d;
  // S1
  logic [6:0] code1_q, code1_d;
  logic [2:0] dot1_q, dot1_d, line1_q, line1_d;
  logic       win1_q, win1_d, xblk1_q, xblk1_d;
  // S2
  logic [8:0] font_a2_q, font_a2_d;
  logic       gv2_q, gv2_d;
  logic [2:0] dot2_q, dot2_d, line2_q, line2_d;
  logic       win2_q, win2_d, xblk2_q, xblk2_d;
  // S3
  logic [4:0] font3_q, font3_d;
  logic       gv3_q, gv3_d;
  logic [2:0] dot3_q, dot3_d, line3_q, line3_d;
  logic       win3_q, win3_d, xblk3_q, xblk3_d;
  // S4
  logic       pix4_q, pix4_d, xblk4_q, xblk4_d;

  logic       mem_we;
  logic [9:0] mem_wa;
  logic [6:0] mem_wd;
  logic [9:0] h_off;
  logic [8:0] v_off;
  logic       in_win;
  logic       busy;

  assign busy = (st_q == ST_CLEAR);

  always_comb begin
    st_d      = st_q;
    clr_a_d   = clr_a_q;
    wr_err_d  = wr_err_q;
    col0_d    = col0_q;   row0_d  = row0_q;  dot0_d  = dot0_q;  line0_d = line0_q;
    win0_d    = win0_q;   xblk0_d = xblk0_q;
    code1_d   = code1_q;  dot1_d  = dot1_q;  line1_d = line1_q;
    win1_d    = win1_q;   xblk1_d = xblk1_q;
    font_a2_d = font_a2_q; gv2_d  = gv2_q;   dot2_d  = dot2_q;  line2_d = line2_q;
    win2_d    = win2_q;   xblk2_d = xblk2_q;
    font3_d   = font3_q;  gv3_d   = gv3_q;   dot3_d  = dot3_q;  line3_d = line3_q;
    win3_d    = win3_q;   xblk3_d = xblk3_q;
    pix4_d    = pix4_q;   xblk4_d = xblk4_q;
    mem_we    = 1'b0;
    mem_wa    = clr_a_q;
    mem_wd    = C_BLANK;

    h_off  = HCTRs_i - 10'(C_H0);
    v_off  = VCTRs_i - 9'(C_V0);
    in_win = (HCTRs_i >= 10'(C_H0)) && (h_off < 10'(C_COLS * 12)) &&
             (VCTRs_i >= 9'(C_V0))  && (v_off < 9'(C_ROWS * 8));

    if (CK_EE_i) begin
      // S0: cell coordinates; forced to cell 0 outside the window so the
      // RAM address never leaves the 768-entry range.
      col0_d  = in_win ? 5'(h_off / 10'd12) : 5'd0;
      dot0_d  = in_win ? 3'((h_off % 10'd12) >> 1) : 3'd0;
      row0_d  = in_win ? v_off[7:3] : 5'd0;
      line0_d = in_win ? v_off[2:0] : 3'd0;
      win0_d  = in_win;
      xblk0_d = XBLK_i;

      // S1: buffer read; a write landing on this same edge is not seen.
      code1_d = txt_mem[{row0_q, col0_q}];
      dot1_d  = dot0_q;  line1_d = line0_q;  win1_d = win0_q;  xblk1_d = xblk0_q;

      // S2: font address; only printable ASCII 0x20..0x5F has a glyph.
      font_a2_d = {6'(code1_q - 7'h20), line1_q};
      gv2_d     = (code1_q >= 7'h20) && (code1_q <= 7'h5F);
      dot2_d    = dot1_q;  line2_d = line1_q;  win2_d = win1_q;  xblk2_d = xblk1_q;

      // S3: font row returns one enabled cycle after the address.
      font3_d = FONT_DATs_i;
      gv3_d   = gv2_q;  dot3_d = dot2_q;  line3_d = line2_q;  win3_d = win2_q;  xblk3_d = xblk2_q;

      // S4: bit 4 is the leftmost dot; dot 5 and line 7 are inter-cell gaps.
      pix4_d  = win3_q && gv3_q && xblk3_q && (line3_q != 3'd7) && (dot3_q != 3'd5) &&
                (|(font3_q & (5'b10000 >> dot3_q)));
      xblk4_d = xblk3_q;

      // Host write port and clear engine share the single RAM write port;
      // the host is locked out while clearing so they never collide.
      wr_err_d = WR_i && (busy || (WR_As_i >= N_CELLS));
      if (st_q == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_a_q;
        mem_wd = C_BLANK;
        if (CLR_i) begin
          clr_a_d = 10'd0;
        end else if (clr_a_q == LAST_CELL) begin
          st_d    = ST_IDLE;
          clr_a_d = 10'd0;
        end else begin
          clr_a_d = clr_a_q + 10'd1;
        end
      end else begin
        if (WR_i && (WR_As_i < N_CELLS)) begin
          mem_we = 1'b1;
          mem_wa = WR_As_i;
          mem_wd = WR_DATs_i;
        end
        if (CLR_i) begin
          st_d    = ST_CLEAR;
          clr_a_d = 10'd0;
        end
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      // Leaving reset always starts a full clear.
      st_q      <= ST_CLEAR;
      clr_a_q   <= 10'd0;
      wr_err_q  <= 1'b0;
      col0_q    <= '0; row0_q  <= '0; dot0_q  <= '0; line0_q <= '0; win0_q <= 1'b0; xblk0_q <= 1'b0;
      code1_q   <= '0; dot1_q  <= '0; line1_q <= '0; win1_q  <= 1'b0; xblk1_q <= 1'b0;
      font_a2_q <= '0; gv2_q   <= 1'b0; dot2_q <= '0; line2_q <= '0; win2_q <= 1'b0; xblk2_q <= 1'b0;
      font3_q   <= '0; gv3_q   <= 1'b0; dot3_q <= '0; line3_q <= '0; win3_q <= 1'b0; xblk3_q <= 1'b0;
      pix4_q    <= 1'b0; xblk4_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      clr_a_q   <= clr_a_d;
      wr_err_q  <= wr_err_d;
      col0_q    <= col0_d;    row0_q  <= row0_d;  dot0_q  <= dot0_d;  line0_q <= line0_d;
      win0_q    <= win0_d;    xblk0_q <= xblk0_d;
      code1_q   <= code1_d;   dot1_q  <= dot1_d;  line1_q <= line1_d;
      win1_q    <= win1_d;    xblk1_q <= xblk1_d;
      font_a2_q <= font_a2_d; gv2_q   <= gv2_d;   dot2_q  <= dot2_d;  line2_q <= line2_d;
      win2_q    <= win2_d;    xblk2_q <= xblk2_d;
      font3_q   <= font3_d;   gv3_q   <= gv3_d;   dot3_q  <= dot3_d;  line3_q <= line3_d;
      win3_q    <= win3_d;    xblk3_q <= xblk3_d;
      pix4_q    <= pix4_d;    xblk4_q <= xblk4_d;
    end
  end

  always_ff @(posedge CK_i) begin
    if (mem_we) begin
      txt_mem[mem_wa] <= mem_wd;
    end
  end

  assign FONT_As_o = font_a2_q;
  assign PIX_o     = pix4_q;
  assign XBLK_o    = xblk4_q;
  assign BUSY_o    = busy;
  assign WR_ERR_o  = wr_err_q;

endmodule

// File: tb/tb_video_text_ovl.sv
module tb_video_text_ovl;

  logic       CK_i = 1'b0;
  logic       XARST_i, CK_EE_i, XBLK_i, WR_i, CLR_i;
  logic [9:0] HCTRs_i, WR_As_i;
  logic [8:0] VCTRs_i;
  logic [6:0] WR_DATs_i;
  logic [8:0] FONT_As_o;
  logic [4:0] FONT_DATs_i;
  logic       PIX_o, XBLK_o, BUSY_o, WR_ERR_o;

  logic [4:0] rom [0:511];
  logic [6:0] tm  [0:767];
  logic [1:0] expq [$];
  logic [1:0] last_exp;
  logic       obs [0:1023];
  int         n_chk = 0;
  int         n_err = 0;

  always #5 CK_i = ~CK_i;

  video_text_ovl dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .CK_EE_i(CK_EE_i),
    .HCTRs_i(HCTRs_i), .VCTRs_i(VCTRs_i), .XBLK_i(XBLK_i),
    .WR_i(WR_i), .WR_As_i(WR_As_i), .WR_DATs_i(WR_DATs_i), .CLR_i(CLR_i),
    .FONT_As_o(FONT_As_o), .FONT_DATs_i(FONT_DATs_i),
    .PIX_o(PIX_o), .XBLK_o(XBLK_o), .BUSY_o(BUSY_o), .WR_ERR_o(WR_ERR_o)
  );

  // Asynchronous font ROM model: data follows the registered address.
  assign FONT_DATs_i = rom[FONT_As_o];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected dot straight from the raster geometry and the text/font contents.
  function automatic logic exp_pix(input int hc, input int vc, input logic xb);
    int h, v, col, dot, row, line, code;
    logic [4:0] f;
    if (!xb || hc < 192 || hc >= 192 + 384 || vc < 40 || vc >= 40 + 192) return 1'b0;
    h = hc - 192;  v = vc - 40;
    col = h / 12;  dot = (h % 12) / 2;
    row = v / 8;   line = v % 8;
    code = int'(tm[row * 32 + col]);
    if (code < 32 || code > 95 || line == 7 || dot == 5) return 1'b0;
    f = rom[(code - 32) * 8 + line];
    return f[4 - dot];
  endfunction

  // One clock; on enabled cycles the output must be the expectation
  // queued five enabled cycles earlier, otherwise it must hold.
  task automatic step(input int hc, input int vc, input logic xb, input logic ee);
    HCTRs_i = 10'(hc);
    VCTRs_i = 9'(vc);
    XBLK_i  = xb;
    CK_EE_i = ee;
    @(posedge CK_i);
    #1;
    if (ee) begin
      expq.push_back({exp_pix(hc, vc, xb), xb});
      last_exp = expq.pop_front();
    end
    chk("pix", PIX_o, last_exp[1]);
    chk("xblk", XBLK_o, last_exp[0]);
  endtask

  task automatic do_reset();
    XARST_i = 1'b0;
    WR_i = 1'b0; CLR_i = 1'b0; CK_EE_i = 1'b1;
    #23;
    chk("rst_pix", PIX_o, 0);
    chk("rst_xblk", XBLK_o, 0);
    chk("rst_font_a", FONT_As_o, 0);
    chk("rst_wr_err", WR_ERR_o, 0);
    chk("rst_busy", BUSY_o, 1);
    @(negedge CK_i);
    XARST_i = 1'b1;
    expq.delete();
    repeat (4) expq.push_back(2'b00);
    last_exp = 2'b00;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (BUSY_o === 1'b1 && n < 2000) begin
      step(0, 0, 1'($urandom_range(0, 1)), 1'b1);
      n++;
    end
    chk(tag, n, 768);
  endtask

  task automatic fill_blank();
    for (int i = 0; i < 768; i++) tm[i] = 7'h20;
  endtask

  task automatic wr(input int a, input int d, input logic exp_err);
    WR_i = 1'b1; WR_As_i = 10'(a); WR_DATs_i = 7'(d);
    step(0, 0, 1'b1, 1'b1);
    WR_i = 1'b0;
    chk($sformatf("wr_err a%0d", a), WR_ERR_o, exp_err);
    if (!exp_err) tm[a] = 7'(d);
    step(0, 0, 1'b1, 1'b1);
    chk($sformatf("wr_err_pulse a%0d", a), WR_ERR_o, 0);
  endtask

  // obs[x] = PIX_o seen while HCTRs_i == x.
  task automatic scan(input int vc, input logic xrand, input logic tog);
    for (int hc = 184; hc <= 584; hc++) begin
      logic xb;
      xb = xrand ? logic'($urandom_range(0, 7) != 0) : 1'b1;
      step(hc, vc, xb, 1'b1);
      obs[hc + 1] = PIX_o;
      if (tog) step($urandom_range(0, 779), $urandom_range(0, 262), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 5'($urandom);
    WR_i = 1'b0; CLR_i = 1'b0; WR_As_i = '0; WR_DATs_i = '0;
    HCTRs_i = '0; VCTRs_i = '0; XBLK_i = 1'b0; CK_EE_i = 1'b1;

    // Reset and power-up clear; then every row read back through the video path.
    do_reset();
    wait_busy("busy_after_reset");
    fill_blank();
    for (int r = 0; r < 24; r++) scan(40 + r * 8 + (r % 8), 1'b1, 1'b0);

    // 'A' in cell 0 with font row 10001: dots 0 and 4 lit.
    rom[{6'h21, 3'd0}] = 5'b10001;
    wr(0, 7'h41, 1'b0);
    scan(40, 1'b0, 1'b0);
    for (int x = 192; x <= 208; x++)
      chk($sformatf("glyph_a h%0d", x), obs[x], (x == 197 || x == 198 || x == 205 || x == 206));

    // Last cell, all-ones font row: dots 0..4 lit, dot 5 dark.
    rom[{6'h3F, 3'd2}] = 5'h1F;
    wr(767, 7'h5F, 1'b0);
    scan(226, 1'b0, 1'b0);
    for (int x = 569; x <= 580; x++)
      chk($sformatf("last_cell h%0d", x), obs[x], (x <= 578));

    // Out-of-range write is dropped and leaves the buffer intact.
    wr(768, 7'h33, 1'b1);
    scan(226, 1'b1, 1'b0);
    scan(40, 1'b1, 1'b0);

    // Code outside the font range stays dark even with all-ones font data.
    rom[{6'h1A, 3'd0}] = 5'h1F;
    wr(1, 7'h7A, 1'b0);
    scan(40, 1'b0, 1'b0);
    for (int x = 209; x <= 220; x++) chk($sformatf("bad_code h%0d", x), obs[x], 0);

    // Line 7 of a cell is always dark.
    rom[{6'h21, 3'd7}] = 5'h1F;
    scan(47, 1'b0, 1'b0);
    for (int x = 197; x <= 208; x++) chk($sformatf("line7 h%0d", x), obs[x], 0);

    // Random contents, random lines (window edges included).
    for (int i = 0; i < 40; i++) wr($urandom_range(0, 767), $urandom_range(0, 127), 1'b0);
    for (int i = 0; i < 10; i++) scan($urandom_range(36, 236), 1'b1, 1'b0);

    // Clock enable toggling with garbage inputs on disabled cycles.
    for (int i = 0; i < 3; i++) scan($urandom_range(38, 234), 1'b1, 1'b1);

    // Clear: write during busy is rejected, CLR_i at address 400 restarts.
    CLR_i = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    CLR_i = 1'b0;
    chk("busy_clr_start", BUSY_o, 1);
    wr(5, 7'h41, 1'b1);
    repeat (398) step(0, 0, 1'($urandom_range(0, 1)), 1'b1);
    CLR_i = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    CLR_i = 1'b0;
    wait_busy("busy_restart");
    fill_blank();
    for (int i = 0; i < 3; i++) scan($urandom_range(40, 231), 1'b1, 1'b0);

    // Reset in the middle of a clear restarts it after release.
    for (int i = 0; i < 10; i++) wr($urandom_range(0, 767), $urandom_range(32, 95), 1'b0);
    CLR_i = 1'b1;
    step(0, 0, 1'b1, 1'b1);
    CLR_i = 1'b0;
    repeat (100) step(0, 0, 1'b1, 1'b1);
    do_reset();
    wait_busy("busy_after_midreset");
    fill_blank();
    scan(40, 1'b1, 1'b0);
    scan(226, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
